mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arb_pick.sv | 27 ++
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_IBUSY = 2'd1,
      ST_DBUSY = 2'd2
   } state_t;

   typedef logic gid_t;
   localparam gid_t GID_I = 1'b0;
   localparam gid_t GID_D = 1'b1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              we;
      logic [DATA_W-1:0] wdata;
   } xfer_t;

   function automatic state_t busy_state(input gid_t g);
      return (g == GID_D) ? ST_DBUSY : ST_IBUSY;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter, bundled as one interface.
interface mem_arbiter_if;
   import mem_arb_pkg::*;

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ready;
   logic              if_err;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ready;
   logic              d_err;

   logic              m_req;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic [DATA_W-1:0] m_rdata;
   logic              m_ack;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
      output if_rdata, if_ready, if_err, d_rdata, d_ready, d_err,
             m_req, m_we, m_addr, m_wdata
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
      input  if_rdata, if_ready, if_err, d_rdata, d_ready, d_err,
             m_req, m_we, m_addr, m_wdata
   );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and data requesters.
// MEMARB_RR_EN selects round-robin; otherwise data has fixed priority.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic if_req,
   input  logic d_req,
`ifdef MEMARB_RR_EN
   input  gid_t last_grant,
`endif
   output logic valid,
   output gid_t winner
);

   always_comb begin
      valid = if_req | d_req;
`ifdef MEMARB_RR_EN
      if (if_req && d_req)
         winner = (last_grant == GID_D) ? GID_I : GID_D;
      else
         winner = d_req ? GID_D : GID_I;
`else
      winner = d_req ? GID_D : GID_I;
`endif
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for fetch and data requesters with access watchdog.
// Build option: MEMARB_RR_EN enables round-robin arbitration (default fixed priority).
//
// state    | meaning
// ST_IDLE  | no access in flight, arbitrating
// ST_IBUSY | fetch access presented to memory
// ST_DBUSY | data access presented to memory
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.slave  bus
);

   localparam int WD_W = $clog2(TIMEOUT + 2);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   state_t          state_q;
   state_t          state_d;
   xfer_t           xfer_q;
   xfer_t           xfer_new;
   logic [WD_W-1:0] wd_cnt;
   logic            pick_valid;
   gid_t            pick_winner;
   logic            busy;
   logic            grant;
   logic            timeout_hit;

`ifdef MEMARB_RR_EN
   gid_t last_grant;

   mem_arb_pick u_pick (
      .if_req     (bus.if_req),
      .d_req      (bus.d_req),
      .last_grant (last_grant),
      .valid      (pick_valid),
      .winner     (pick_winner)
   );

   // Reset value GID_D means fetch wins the first contested grant.
   always_ff @(posedge clk) begin
      if (reset)
         last_grant <= GID_D;
      else if (grant)
         last_grant <= pick_winner;
   end
`else
   mem_arb_pick u_pick (
      .if_req (bus.if_req),
      .d_req  (bus.d_req),
      .valid  (pick_valid),
      .winner (pick_winner)
   );
`endif

   assign busy        = (state_q != ST_IDLE);
   assign grant       = (state_q == ST_IDLE) && pick_valid;
   assign timeout_hit = (TIMEOUT != 0) && busy && !bus.m_ack && (wd_cnt == WD_LAST);

   always_comb begin
      xfer_new = '0;
      if (pick_winner == GID_D) begin
         xfer_new.addr  = bus.d_addr;
         xfer_new.we    = bus.d_we;
         xfer_new.wdata = bus.d_we ? bus.d_wdata : '0;
      end else begin
         xfer_new.addr  = bus.if_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         xfer_q <= '0;
         wd_cnt <= '0;
      end else if (grant) begin
         xfer_q <= xfer_new;
         wd_cnt <= '0;
      end else if (busy && !bus.m_ack) begin
         wd_cnt <= wd_cnt + WD_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (pick_valid) state_d = busy_state(pick_winner);
         ST_IBUSY,
         ST_DBUSY: if (bus.m_ack || timeout_hit) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Completion pulses are suppressed in a reset cycle so an aborted access stays silent.
   always_comb begin
      bus.m_req    = busy;
      bus.m_we     = busy && xfer_q.we;
      bus.m_addr   = xfer_q.addr;
      bus.m_wdata  = xfer_q.wdata;
      bus.if_ready = (state_q == ST_IBUSY) && bus.m_ack && !reset;
      bus.d_ready  = (state_q == ST_DBUSY) && bus.m_ack && !reset;
      bus.if_err   = (state_q == ST_IBUSY) && timeout_hit && !reset;
      bus.d_err    = (state_q == ST_DBUSY) && timeout_hit && !reset;
      bus.if_rdata = bus.if_ready ? bus.m_rdata : '0;
      bus.d_rdata  = bus.d_ready  ? bus.m_rdata : '0;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter (TIMEOUT=4); follows MEMARB_RR_EN if defined.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int K_IRDY = 0;
   localparam int K_DRDY = 1;
   localparam int K_IERR = 2;
   localparam int K_DERR = 3;
`ifdef MEMARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   typedef struct {
      int          kind;
      logic [31:0] rd;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_arbiter_if bus();

   mem_arbiter #(.TIMEOUT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   bit   last_d   = 1'b1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit pick_d(input bit i, input bit d);
      if (i && d) return RR ? !last_d : 1'b1;
      return d;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
      bus.m_ack = 1'b0;
   endtask

   task automatic observe();
      int          got;
      logic [31:0] got_rd;
      exp_t        e;
      @(negedge clk);
      chk("ready_mutex", {31'b0, bus.if_ready & bus.d_ready}, 32'd0);
      if (bus.if_ready || bus.d_ready || bus.if_err || bus.d_err) begin
         if (bus.d_err)        got = K_DERR;
         else if (bus.if_err)  got = K_IERR;
         else if (bus.d_ready) got = K_DRDY;
         else                  got = K_IRDY;
         got_rd = (got == K_DRDY) ? bus.d_rdata : bus.if_rdata;
         if (sb.size() == 0) begin
            chk("unexpected_pulse", 32'(got), 32'd99);
         end else begin
            e = sb.pop_front();
            chk("pulse_kind", 32'(got), 32'(e.kind));
            if (got < K_IERR) chk("rdata", got_rd, e.rd);
         end
      end
   endtask

   task automatic serve(input bit is_d, input int wt, input logic [31:0] rd,
                        input logic [31:0] ea, input logic ew, input logic [31:0] ewd,
                        input bit scramble);
      int n    = 0;
      bit done = 1'b0;
      last_d = is_d;
      for (int cyc = 0; cyc < 20 && !done; cyc++) begin
         next_cycle();
         if (bus.m_req) begin
            chk("m_addr", bus.m_addr, ea);
            chk("m_we", {31'b0, bus.m_we}, {31'b0, ew});
            chk("m_wdata", bus.m_wdata, ewd);
            if (scramble) begin
               bus.d_addr  = 32'hFFFF_FFF0;
               bus.d_wdata = 32'h0;
               bus.d_we    = 1'b0;
            end
            if (n == wt) begin
               bus.m_ack   = 1'b1;
               bus.m_rdata = rd;
               sb.push_back('{is_d ? K_DRDY : K_IRDY, rd});
               done = 1'b1;
            end
            n++;
         end
         observe();
      end
      chk("serve_done", {31'b0, done}, 32'd1);
      chk("sb_drain", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      bit first_d;
      reset       = 1'b1;
      bus.if_req  = 1'b0;
      bus.if_addr = '0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = '0;
      bus.d_wdata = '0;
      bus.m_rdata = '0;
      bus.m_ack   = 1'b0;
      next_cycle();
      next_cycle();
      observe();
      chk("rst_m_req", {31'b0, bus.m_req}, 32'd0);
      chk("rst_m_we", {31'b0, bus.m_we}, 32'd0);
      chk("rst_m_addr", bus.m_addr, 32'd0);
      chk("rst_m_wdata", bus.m_wdata, 32'd0);
      chk("rst_pulses", {28'b0, bus.if_ready, bus.d_ready, bus.if_err, bus.d_err}, 32'd0);
      next_cycle();
      reset = 1'b0;
      observe();

      // fetch only, immediate ack
      next_cycle();
      bus.if_req = 1'b1; bus.if_addr = 32'h0000_0040;
      observe();
      serve(1'b0, 0, 32'h2008_0005, 32'h0000_0040, 1'b0, 32'h0, 1'b0);
      next_cycle();
      bus.if_req = 1'b0;
      observe();

      // both requesting in the same idle cycle
      next_cycle();
      bus.if_req = 1'b1; bus.if_addr = 32'h0000_0044;
      bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0100; bus.d_wdata = 32'h5555_5555;
      observe();
      first_d = pick_d(1'b1, 1'b1);
      if (first_d) begin
         serve(1'b1, 1, 32'h1111_0000, 32'h0000_0100, 1'b0, 32'h0, 1'b0);
         next_cycle(); bus.d_req = 1'b0; observe();
         serve(1'b0, 0, 32'h2222_0000, 32'h0000_0044, 1'b0, 32'h0, 1'b0);
         next_cycle(); bus.if_req = 1'b0; observe();
      end else begin
         serve(1'b0, 1, 32'h2222_0000, 32'h0000_0044, 1'b0, 32'h0, 1'b0);
         next_cycle(); bus.if_req = 1'b0; observe();
         serve(1'b1, 0, 32'h1111_0000, 32'h0000_0100, 1'b0, 32'h0, 1'b0);
         next_cycle(); bus.d_req = 1'b0; observe();
      end

      // both held across four transactions
      next_cycle();
      bus.if_req = 1'b1; bus.if_addr = 32'h0000_0080;
      bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0200; bus.d_wdata = 32'h7777_7777;
      observe();
      for (int t = 0; t < 4; t++) begin
         bit wd;
         wd = pick_d(1'b1, 1'b1);
         serve(wd, t % 2, 32'hC000_0000 + 32'(t), wd ? 32'h0000_0200 : 32'h0000_0080,
               1'b0, 32'h0, 1'b0);
      end
      next_cycle();
      bus.if_req = 1'b0; bus.d_req = 1'b0;
      observe();

      // store with requester inputs disturbed mid-access
      next_cycle();
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_0054; bus.d_wdata = 32'hABCD_1234;
      observe();
      serve(1'b1, 2, 32'h0, 32'h0000_0054, 1'b1, 32'hABCD_1234, 1'b1);
      next_cycle();
      bus.d_req = 1'b0; bus.d_we = 1'b0;
      observe();

      // stray ack in idle; outputs hold last access values
      next_cycle();
      bus.m_ack = 1'b1; bus.m_rdata = 32'hFEED_0001;
      observe();
      chk("idle_ack_if_ready", {31'b0, bus.if_ready}, 32'd0);
      chk("idle_ack_d_ready", {31'b0, bus.d_ready}, 32'd0);
      chk("idle_m_addr", bus.m_addr, 32'h0000_0054);
      chk("idle_m_wdata", bus.m_wdata, 32'hABCD_1234);
      chk("idle_m_we", {31'b0, bus.m_we}, 32'd0);
      next_cycle();
      observe();
      chk("idle_ack_m_req", {31'b0, bus.m_req}, 32'd0);

      // watchdog: no ack at all
      next_cycle();
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_0060; bus.d_wdata = 32'h0000_1234;
      observe();
      last_d = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         next_cycle();
         chk("wd_m_req", {31'b0, bus.m_req}, 32'd1);
         if (i == 4) sb.push_back('{K_DERR, 32'h0});
         observe();
         chk("wd_d_err", {31'b0, bus.d_err}, (i == 4) ? 32'd1 : 32'd0);
      end
      next_cycle();
      bus.d_req = 1'b0; bus.d_we = 1'b0;
      observe();
      chk("wd_after_m_req", {31'b0, bus.m_req}, 32'd0);
      chk("wd_after_d_err", {31'b0, bus.d_err}, 32'd0);
      chk("wd_sb_drain", 32'(sb.size()), 32'd0);

      // reset during fetch access, ack arriving in the reset cycle
      next_cycle();
      bus.if_req = 1'b1; bus.if_addr = 32'h0000_0090;
      observe();
      next_cycle();
      chk("rst_busy_m_req", {31'b0, bus.m_req}, 32'd1);
      reset = 1'b1; bus.m_ack = 1'b1; bus.m_rdata = 32'hBAD0_BAD0;
      observe();
      chk("rst_busy_if_ready", {31'b0, bus.if_ready}, 32'd0);
      next_cycle();
      reset = 1'b0; bus.if_req = 1'b0;
      last_d = 1'b1;
      observe();
      chk("rst_after_m_req", {31'b0, bus.m_req}, 32'd0);
      chk("rst_after_m_addr", bus.m_addr, 32'd0);
      chk("rst_after_if_ready", {31'b0, bus.if_ready}, 32'd0);
      chk("rst_sb_drain", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
